// File: rtl/minv_pkg.sv
// Shared definitions for the MINV core, its host-side controller and the bus wrapper.
package minv_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned N_WORDS = 16;
  localparam int unsigned OP_W    = WORD_W * N_WORDS;
  localparam int unsigned CNT_W   = $clog2(N_WORDS);

  localparam logic [1:0] FLAG_TMO = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadP,
    StKick,
    StWait,
    StRead,
    StDone
  } minv_state_e;

endpackage

// File: rtl/minv_if.sv
// Word-serial link between the host controller (master) and the MINV core (slave).
interface minv_if;
  import minv_pkg::*;

  logic [WORD_W-1:0] datain;
  logic              loada;
  logic              loadp;
  logic              minv_en;
  logic              outx1;
  logic              minv_rdy;
  logic [1:0]        minv_flag;
  logic [WORD_W-1:0] regx1out;

  modport master (
    output datain, loada, loadp, minv_en, outx1,
    input  minv_rdy, minv_flag, regx1out
  );

  modport slave (
    input  datain, loada, loadp, minv_en, outx1,
    output minv_rdy, minv_flag, regx1out
  );

endinterface

// File: rtl/minv_word_shifter.sv
// Operand-wide shift register: parallel load, shifts right one word per cycle,
// low word is the serial output and sin enters at the MSB side.
module minv_word_shifter
  import minv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [OP_W-1:0]   load_data,
  input  logic              shift,
  input  logic [WORD_W-1:0] sin,
  output logic [OP_W-1:0]   q
);

  logic [OP_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= load_data;
    end else if (shift) begin
      q_q <= {sin, q_q[OP_W-1:WORD_W]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/minv_host_ctrl.sv
// Host-side initiator for the MINV core: streams a and p word-serially, kicks the core,
// waits for ready under a watchdog and drains x1 back into a 256-bit result.
module minv_host_ctrl
  import minv_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned TMO_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] a_in,
  input  logic [OP_W-1:0] p_in,
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] result,
  output logic [1:0]      flag,
  minv_if.master          core
);

  minv_state_e       state_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [OP_W-1:0]   p_q;
  logic              busy_q, done_q, loada_q, loadp_q, minv_en_q, outx1_q;
  logic [1:0]        flag_q;

  logic            accept, last_word, rx_vld, rdy_take, tmo_hit;
  logic            tx_load, tx_shift, rx_load, rx_shift;
  logic [OP_W-1:0] tx_q;

  assign accept    = (state_q == StIdle) && start;
  assign last_word = (word_cnt_q == CNT_W'(N_WORDS - 1));
  assign rx_vld    = vld_pipe_q[RD_LAT-1];
  // A ready still high from the previous operation must not be taken in the first WAIT cycle.
  assign rdy_take  = core.minv_rdy && (tmo_cnt_q != '0);
  assign tmo_hit   = (tmo_cnt_q == {{(TMO_W-1){1'b1}}, 1'b0});

  // The tx register holds a, then is reloaded with p on the last LOAD_A cycle so that
  // the P words follow with no gap; zeros shift in, leaving datain at 0 afterwards.
  assign tx_load  = accept || ((state_q == StLoadA) && last_word);
  assign tx_shift = (state_q == StLoadA) || (state_q == StLoadP);
  assign rx_load  = (state_q == StWait) && !rdy_take && tmo_hit;
  assign rx_shift = (state_q == StRead) && rx_vld;

  minv_word_shifter u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_data (accept ? a_in : p_q),
    .shift     (tx_shift),
    .sin       ('0),
    .q         (tx_q)
  );

  minv_word_shifter u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rx_load),
    .load_data ('0),
    .shift     (rx_shift),
    .sin       (core.regx1out),
    .q         (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      rx_cnt_q   <= '0;
      tmo_cnt_q  <= '0;
      vld_pipe_q <= '0;
      p_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      loada_q    <= 1'b0;
      loadp_q    <= 1'b0;
      minv_en_q  <= 1'b0;
      outx1_q    <= 1'b0;
      flag_q     <= 2'b00;
    end else begin
      done_q     <= 1'b0;
      minv_en_q  <= 1'b0;
      // Delay line marking the cycles on which a requested x1 word is on regx1out.
      vld_pipe_q <= RD_LAT'({vld_pipe_q, outx1_q});
      unique case (state_q)
        StIdle: begin
          if (start) begin
            p_q        <= p_in;
            busy_q     <= 1'b1;
            loada_q    <= 1'b1;
            word_cnt_q <= '0;
            state_q    <= StLoadA;
          end
        end
        StLoadA: begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
          if (last_word) begin
            loada_q <= 1'b0;
            loadp_q <= 1'b1;
            state_q <= StLoadP;
          end
        end
        StLoadP: begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
          if (last_word) begin
            loadp_q   <= 1'b0;
            minv_en_q <= 1'b1;
            state_q   <= StKick;
          end
        end
        StKick: begin
          tmo_cnt_q <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          if (rdy_take) begin
            flag_q     <= core.minv_flag;
            outx1_q    <= 1'b1;
            word_cnt_q <= '0;
            rx_cnt_q   <= '0;
            state_q    <= StRead;
          end else if (tmo_hit) begin
            flag_q  <= FLAG_TMO;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        StRead: begin
          if (outx1_q) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (last_word) begin
              outx1_q <= 1'b0;
            end
          end
          if (rx_vld) begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            if (rx_cnt_q == CNT_W'(N_WORDS - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign flag         = flag_q;
  assign core.datain  = tx_q[WORD_W-1:0];
  assign core.loada   = loada_q;
  assign core.loadp   = loadp_q;
  assign core.minv_en = minv_en_q;
  assign core.outx1   = outx1_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({loada_q, loadp_q, minv_en_q, outx1_q}));

  a_tx_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StKick) |-> (tx_q == '0));

endmodule
